// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I core pipeline: datapath width, reset vector,
// the bubble instruction and the register-field positions inside an instruction.
package riscv_pkg;

   localparam int          XLEN         = 32;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0

   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;
   localparam int REG_W   = 5;

   // Extract a register specifier starting at bit lsb of an instruction word.
   function automatic logic [REG_W-1:0] reg_field(input logic [31:0] instr, input int lsb);
      return instr[lsb +: REG_W];
   endfunction

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Bundle between the fetch/IF-ID stage and its surroundings: hazard-unit
// controls, the redirect from E, the instruction-memory port and the D outputs.
// master = the fetch stage, slave = the rest of the core / instruction memory.
interface fetch_ifid_stage_if #(
   parameter int XLEN = riscv_pkg::XLEN
);

   // hazard unit / execute stage -> fetch
   logic                      StallF;
   logic                      StallD;
   logic                      FlushD;
   logic                      PCSrcE;
   logic [XLEN-1:0]           PCTargetE;

   // instruction memory
   logic [XLEN-1:0]           PCF;
   logic [31:0]               imem_rdata;

   // decode-stage view
   logic [31:0]               InstrD;
   logic [XLEN-1:0]           PCD;
   logic [XLEN-1:0]           PCPlus4D;
   logic                      ValidD;
   logic [riscv_pkg::REG_W-1:0] rs1D;
   logic [riscv_pkg::REG_W-1:0] rs2D;
   logic [riscv_pkg::REG_W-1:0] rdD;

   modport master (
      input  StallF, StallD, FlushD, PCSrcE, PCTargetE, imem_rdata,
      output PCF, InstrD, PCD, PCPlus4D, ValidD, rs1D, rs2D, rdD
   );

   modport slave (
      output StallF, StallD, FlushD, PCSrcE, PCTargetE, imem_rdata,
      input  PCF, InstrD, PCD, PCPlus4D, ValidD, rs1D, rs2D, rdD
   );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: async active-low reset and synchronous clear both
// load CLR_VAL; clear has priority over the load enable.
module pipe_reg_en_clr #(
   parameter int           W       = 32,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Register with reset, then clear, then enable priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= CLR_VAL;
      end else if (clr) begin
         q <= CLR_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Fetch stage plus IF/ID register. Owns the PC, addresses instruction memory
// and captures the returned word together with its PC into the decode stage.
// A redirect from E overrides a fetch stall; a flush overrides a decode stall.
module fetch_ifid_stage #(
   parameter int              XLEN         = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
   parameter logic [31:0]     NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                rst_n,
   fetch_ifid_stage_if.master  bus
);

   import riscv_pkg::reg_field;
   import riscv_pkg::RS1_LSB;
   import riscv_pkg::RS2_LSB;
   import riscv_pkg::RD_LSB;

   // ---------------- PC register ----------------
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_next;
   logic            pc_en;

   // Wraps naturally modulo 2^XLEN.
   assign pc_plus4 = pc_reg + XLEN'(4);
   // Redirect target is passed through untouched, including its low bits.
   assign pc_next  = bus.PCSrcE ? bus.PCTargetE : pc_plus4;
   // A redirect must be taken even while fetch is stalled.
   assign pc_en    = bus.PCSrcE | ~bus.StallF;

   pipe_reg_en_clr #(
      .W       (XLEN),
      .CLR_VAL (RESET_VECTOR)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pc_en),
      .clr   (1'b0),
      .d     (pc_next),
      .q     (pc_reg)
   );

   // ---------------- IF/ID register ----------------
   // Packed as {instr, pc, pc+4, valid}; the bubble value doubles as reset value.
   localparam int                IFID_W      = 32 + 2 * XLEN + 1;
   localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}, 1'b0};

   logic [IFID_W-1:0] ifid_d;
   logic [IFID_W-1:0] ifid_q;
   logic [31:0]       instr_d;
   logic [XLEN-1:0]   pc_d;
   logic [XLEN-1:0]   pc_plus4_d;
   logic              valid_d;

   assign ifid_d = {bus.imem_rdata, pc_reg, pc_plus4, 1'b1};

   pipe_reg_en_clr #(
      .W       (IFID_W),
      .CLR_VAL (IFID_BUBBLE)
   ) u_ifid_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~bus.StallD),
      .clr   (bus.FlushD),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign {instr_d, pc_d, pc_plus4_d, valid_d} = ifid_q;

   // ---------------- outputs ----------------
   assign bus.PCF      = pc_reg;
   assign bus.InstrD   = instr_d;
   assign bus.PCD      = pc_d;
   assign bus.PCPlus4D = pc_plus4_d;
   assign bus.ValidD   = valid_d;

   // Register specifiers for load-use detection; the bubble decodes to x0.
   assign bus.rs1D = reg_field(instr_d, RS1_LSB);
   assign bus.rs2D = reg_field(instr_d, RS2_LSB);
   assign bus.rdD  = reg_field(instr_d, RD_LSB);

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage: reset, free run, stall, redirect/flush,
// redirect during stall, asynchronous reset and PC wrap-around.
module tb_fetch_ifid_stage;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   fetch_ifid_stage_if #(.XLEN(32)) bus ();

   fetch_ifid_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory: a few real instructions at the bottom, a tagged
   // pattern {addr[15:0], 16'h0033} everywhere else.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;  // addi x1,x0,5
         32'h0000_0004: return 32'h0020_8133;  // add  x2,x1,x2
         32'h0000_0008: return 32'h0031_00B3;  // add  x1,x2,x3
         32'h0000_000C: return 32'h0041_8233;  // add  x4,x3,x4
         default:       return {a[15:0], 16'h0033};
      endcase
   endfunction

   assign bus.imem_rdata = imem_word(bus.PCF);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic valid);
      chk({tag, ".InstrD"},   bus.InstrD,   instr);
      chk({tag, ".PCD"},      bus.PCD,      pc);
      chk({tag, ".PCPlus4D"}, bus.PCPlus4D, pc4);
      chk({tag, ".ValidD"},   {31'd0, bus.ValidD}, {31'd0, valid});
   endtask

   task automatic chk_regs(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd);
      chk({tag, ".rs1D"}, {27'd0, bus.rs1D}, {27'd0, rs1});
      chk({tag, ".rs2D"}, {27'd0, bus.rs2D}, {27'd0, rs2});
      chk({tag, ".rdD"},  {27'd0, bus.rdD},  {27'd0, rd});
   endtask

   task automatic set_ctl(input logic stall, input logic flush, input logic redir,
                          input logic [31:0] target);
      bus.StallF    = stall;
      bus.StallD    = stall;
      bus.FlushD    = flush;
      bus.PCSrcE    = redir;
      bus.PCTargetE = target;
   endtask

   // Cycle watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      set_ctl(1'b0, 1'b0, 1'b0, 32'h0);

      // ---- 1. reset and free run ----
      #2 rst_n = 1'b0;
      #1;
      chk("rst.PCF", bus.PCF, 32'h0);
      chk_d("rst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
      chk_regs("rst", 5'd0, 5'd0, 5'd0);
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("run0.PCF", bus.PCF, 32'h0);
      step();
      chk("run1.PCF", bus.PCF, 32'h4);
      chk_d("run1", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
      chk_regs("run1", 5'd0, 5'd5, 5'd1);
      step();
      chk("run2.PCF", bus.PCF, 32'h8);
      chk_d("run2", 32'h0020_8133, 32'h4, 32'h8, 1'b1);
      chk_regs("run2", 5'd1, 5'd2, 5'd2);

      // ---- 2. two-cycle stall at PCF=8 ----
      set_ctl(1'b1, 1'b0, 1'b0, 32'h0);
      step();
      chk("stall1.PCF", bus.PCF, 32'h8);
      chk_d("stall1", 32'h0020_8133, 32'h4, 32'h8, 1'b1);
      step();
      chk("stall2.PCF", bus.PCF, 32'h8);
      chk_d("stall2", 32'h0020_8133, 32'h4, 32'h8, 1'b1);
      set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk("unstall1.PCF", bus.PCF, 32'hC);
      chk_d("unstall1", 32'h0031_00B3, 32'h8, 32'hC, 1'b1);
      chk_regs("unstall1", 5'd2, 5'd3, 5'd1);
      step();
      chk("unstall2.PCF", bus.PCF, 32'h10);
      chk_d("unstall2", 32'h0041_8233, 32'hC, 32'h10, 1'b1);

      // ---- 3. redirect + flush at PCF=0x10 ----
      set_ctl(1'b0, 1'b1, 1'b1, 32'h100);
      step();
      chk("redir.PCF", bus.PCF, 32'h100);
      chk_d("redir", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
      chk_regs("redir", 5'd0, 5'd0, 5'd0);
      set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk("redir_next.PCF", bus.PCF, 32'h104);
      chk_d("redir_next", 32'h0100_0033, 32'h100, 32'h104, 1'b1);

      // ---- 4. redirect + flush while stalled, unaligned target ----
      set_ctl(1'b1, 1'b1, 1'b1, 32'h202);
      step();
      chk("redir_stall.PCF", bus.PCF, 32'h202);
      chk_d("redir_stall", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
      set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk("redir_stall_next.PCF", bus.PCF, 32'h206);
      chk_d("redir_stall_next", 32'h0202_0033, 32'h202, 32'h206, 1'b1);

      // ---- 5. asynchronous reset mid-cycle at PCF=0x40 ----
      set_ctl(1'b0, 1'b1, 1'b1, 32'h40);
      step();
      set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk("pre_arst.PCF", bus.PCF, 32'h44);
      chk("pre_arst.ValidD", {31'd0, bus.ValidD}, 32'd1);
      set_ctl(1'b1, 1'b0, 1'b0, 32'h0);
      step();
      chk("hold40.PCF", bus.PCF, 32'h44);
      // Reach 0x40 exactly via a redirect, then pulse reset between edges.
      set_ctl(1'b0, 1'b0, 1'b1, 32'h40);
      step();
      set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
      chk("at40.PCF", bus.PCF, 32'h40);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.PCF", bus.PCF, 32'h0);
      chk_d("arst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
      #1 rst_n = 1'b1;
      #1;
      chk("arst_rel.PCF", bus.PCF, 32'h0);
      step();
      chk("arst_run.PCF", bus.PCF, 32'h4);
      chk_d("arst_run", 32'h0050_0093, 32'h0, 32'h4, 1'b1);

      // ---- 6. PC wrap-around ----
      set_ctl(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      step();
      chk("wrap0.PCF", bus.PCF, 32'hFFFF_FFFC);
      set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk("wrap1.PCF", bus.PCF, 32'h0);
      chk_d("wrap1", 32'hFFFC_0033, 32'hFFFF_FFFC, 32'h0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
